// File: rtl/divider24bit_seq_if.sv
// Handshake and result bundle between the execute-stage control and the divider.
// master: control side (drives start/operands); slave: divider (drives busy/done/results).
interface divider24bit_seq_if #(
   parameter int WIDTH = 24
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             zero;
   logic             divbyzero;
   logic             overflow;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder,
      input  zero, divbyzero, overflow
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder,
      output zero, divbyzero, overflow
   );
endinterface

// File: rtl/divider24bit_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, 25-cycle latency.
// Ports: clk, rst (async high), bus (slave: start/operands in, busy/done/results/flags out).
module divider24bit_seq #(
   parameter int WIDTH    = 24,
   parameter int CNT_BITS = 5
) (
   input logic             clk,
   input logic             rst,
   divider24bit_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t              state;
   logic [CNT_BITS-1:0] cnt;
   logic                sgn;
   logic                neg_a;
   logic                neg_b;
   logic [WIDTH-1:0]    dvs;
   logic [WIDTH-1:0]    dq;
   logic [WIDTH-1:0]    rem;

   logic [WIDTH-1:0]    mag_a;
   logic [WIDTH-1:0]    mag_b;
   logic [WIDTH:0]      shl;
   logic [WIDTH:0]      diff;
   logic                neg_q;
   logic [WIDTH-1:0]    q_fin;
   logic [WIDTH-1:0]    r_fin;

   always_comb begin
      mag_a = bus.dividend;
      mag_b = bus.divisor;
      if (bus.is_signed && bus.dividend[WIDTH-1])
         mag_a = -bus.dividend;
      if (bus.is_signed && bus.divisor[WIDTH-1])
         mag_b = -bus.divisor;
      // dq holds the unconsumed dividend bits in its top and
      // collects quotient bits at the bottom as they shift out.
      shl   = {rem, dq[WIDTH-1]};
      // Partial remainder stays below the divisor, so bit WIDTH
      // of the 25-bit difference is a clean borrow flag.
      diff  = shl - {1'b0, dvs};
      neg_q = sgn & (neg_a ^ neg_b);
      // A zero divisor yields all ones whatever the signs.
      if (dvs == '0)
         q_fin = '1;
      else if (neg_q)
         q_fin = -dq;
      else
         q_fin = dq;
      r_fin = (sgn & neg_a) ? -rem : rem;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         sgn           <= 1'b0;
         neg_a         <= 1'b0;
         neg_b         <= 1'b0;
         dvs           <= '0;
         dq            <= '0;
         rem           <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.zero      <= 1'b0;
         bus.divbyzero <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sgn      <= bus.is_signed;
                  neg_a    <= bus.is_signed & bus.dividend[WIDTH-1];
                  neg_b    <= bus.is_signed & bus.divisor[WIDTH-1];
                  dq       <= mag_a;
                  dvs      <= mag_b;
                  rem      <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (!diff[WIDTH])
                  rem <= diff[WIDTH-1:0];
               else
                  rem <= shl[WIDTH-1:0];
               dq  <= {dq[WIDTH-2:0], ~diff[WIDTH]};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_BITS'(WIDTH - 1))
                  state <= FIN;
            end
            FIN: begin
               bus.quotient  <= q_fin;
               bus.remainder <= r_fin;
               bus.zero      <= (q_fin == '0);
               bus.divbyzero <= (dvs == '0);
               // Only -2^23 / -1 gives a same-sign magnitude with MSB set.
               bus.overflow  <= sgn & ~(neg_a ^ neg_b)
                              & dq[WIDTH-1] & (dvs != '0);
               bus.busy      <= 1'b0;
               bus.done      <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider24bit_seq.sv
// Randomised self-checking bench for divider24bit_seq.
// Directed corner cases plus random operands against an arithmetic model.
module tb_divider24bit_seq;

   logic clk;
   logic rst;
   int   npass;
   int   ntot;

   divider24bit_seq_if #(.WIDTH(24)) bus ();

   divider24bit_seq #(
      .WIDTH(24),
      .CNT_BITS(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      ntot++;
      if (got === exp)
         npass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model(input logic [23:0] a, input logic [23:0] b,
                        input logic s,
                        output logic [23:0] q, output logic [23:0] r,
                        output logic z, output logic dz,
                        output logic ov);
      int sa, sb, qi, ri;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 24'd0) begin
         q  = 24'hFFFFFF;
         r  = a;
         dz = 1'b1;
      end else if (s) begin
         sa = a[23] ? int'(a) - 16777216 : int'(a);
         sb = b[23] ? int'(b) - 16777216 : int'(b);
         if (sa == -8388608 && sb == -1) begin
            q  = 24'h800000;
            r  = 24'd0;
            ov = 1'b1;
         end else begin
            qi = sa / sb;
            ri = sa % sb;
            q  = qi[23:0];
            r  = ri[23:0];
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      z = (q == 24'd0);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic chk_res(input string tag,
                          input logic [23:0] a, input logic [23:0] b,
                          input logic s);
      logic [23:0] q, r;
      logic z, dz, ov;
      model(a, b, s, q, r, z, dz, ov);
      chk({tag, ":q"}, 64'(bus.quotient), 64'(q));
      chk({tag, ":r"}, 64'(bus.remainder), 64'(r));
      chk({tag, ":zero"}, 64'(bus.zero), 64'(z));
      chk({tag, ":dbz"}, 64'(bus.divbyzero), 64'(dz));
      chk({tag, ":ovf"}, 64'(bus.overflow), 64'(ov));
      chk({tag, ":busy_done"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic run_op(input string tag,
                         input logic [23:0] a, input logic [23:0] b,
                         input logic s);
      int lat;
      @(negedge clk);
      bus.dividend  = a;
      bus.divisor   = b;
      bus.is_signed = s;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.dividend  = 24'($urandom);
      bus.divisor   = 24'($urandom);
      bus.is_signed = 1'($urandom);
      chk({tag, ":busy"}, 64'(bus.busy), 64'd1);
      wait_done(lat);
      chk({tag, ":lat"}, 64'(lat), 64'd25);
      chk_res(tag, a, b, s);
   endtask

   initial begin
      int lat;
      int seen;
      logic [23:0] a, b;
      npass         = 0;
      ntot          = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", {11'd0, bus.busy, bus.done, bus.quotient,
                    bus.remainder, bus.zero, bus.divbyzero,
                    bus.overflow}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("u100_7", 24'd100, 24'd7, 1'b0);
      chk("u100_7:q14", 64'(bus.quotient), 64'h00000E);
      run_op("s-7_2", 24'hFFFFF9, 24'h000002, 1'b1);
      chk("s-7_2:qconst", 64'(bus.quotient), 64'hFFFFFD);
      run_op("dz_u", 24'h123456, 24'd0, 1'b0);
      run_op("dz_s", 24'h123456, 24'd0, 1'b1);
      chk("dz_s:qconst", 64'(bus.quotient), 64'hFFFFFF);
      run_op("ovf_s", 24'h800000, 24'hFFFFFF, 1'b1);
      chk("ovf_s:qconst", 64'(bus.quotient), 64'h800000);
      run_op("ovf_u", 24'h800000, 24'hFFFFFF, 1'b0);
      run_op("dz_neg", 24'h800001, 24'd0, 1'b1);

      // Start during busy is ignored; start in Done cycle is taken.
      @(negedge clk);
      bus.dividend  = 24'd100;
      bus.divisor   = 24'd7;
      bus.is_signed = 1'b0;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (i == 9) begin
            bus.dividend = 24'd9;
            bus.divisor  = 24'd3;
            bus.start    = 1'b1;
         end
         if (i == 10)
            bus.start = 1'b0;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      chk("ign:lat", 64'(lat), 64'd25);
      chk("ign:q", 64'(bus.quotient), 64'd14);
      chk("ign:r", 64'(bus.remainder), 64'd2);
      bus.dividend = 24'd9;
      bus.divisor  = 24'd3;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("donestart:busy", 64'(bus.busy), 64'd1);
      wait_done(lat);
      chk("donestart:lat", 64'(lat), 64'd25);
      chk("donestart:q", 64'(bus.quotient), 64'd3);
      chk("donestart:r", 64'(bus.remainder), 64'd0);

      // Start held high: one result every 26 cycles.
      @(negedge clk);
      bus.dividend  = 24'd50;
      bus.divisor   = 24'd5;
      bus.is_signed = 1'b0;
      bus.start     = 1'b1;
      wait_done(lat);
      wait_done(lat);
      bus.start = 1'b0;
      chk("b2b:gap", 64'(lat), 64'd26);
      chk("b2b:q", 64'(bus.quotient), 64'd10);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      bus.dividend = 24'd1000;
      bus.divisor  = 24'd3;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst", {11'd0, bus.busy, bus.done, bus.quotient,
                     bus.remainder, bus.zero, bus.divbyzero,
                     bus.overflow}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy)
            seen++;
      end
      chk("midrst:stray", 64'(seen), 64'd0);
      run_op("postrst", 24'hFFFFFF, 24'h000010, 1'b0);
      chk("postrst:qconst", 64'(bus.quotient), 64'h0FFFFF);
      chk("postrst:rconst", 64'(bus.remainder), 64'h00000F);

      for (int n = 0; n < 60; n++) begin
         a = 24'($urandom);
         b = 24'($urandom);
         case ($urandom_range(0, 7))
            0: b = 24'd0;
            1: b = 24'hFFFFFF;
            2: b = 24'($urandom_range(1, 15));
            3: a = 24'h800000;
            default: ;
         endcase
         run_op($sformatf("rnd%0d", n), a, b, 1'($urandom));
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
